// File: rtl/imem_fetch_ctrl.sv
// Instruction-supply stage: on-chip program RAM plus a LOAD/RUN/DRAIN/DONE
// sequencer that drives pcEn and returns the instruction addressed by pc.
module imem_fetch_ctrl #(
    parameter int DEPTH        = 800,
    parameter int AW           = 10,
    parameter int RUN_CYCLES   = 804,
    parameter int DRAIN_CYCLES = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_valid,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          load_done,
    input  logic          restart,
    input  logic [31:0]   pc,
    input  logic          OpDone,
    output logic [31:0]   inst,
    output logic          pcEn,
    output logic          run_done,
    output logic          fault,
    output logic [15:0]   cycle_cnt
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [15:0]    cycle_cnt_q, cycle_cnt_d;
    logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
    logic           fault_q, fault_d;
    logic           pc_en_q, pc_en_d;
    logic           run_done_q, run_done_d;
    logic [31:0]    inst_q;

    logic [31:0]    mem [DEPTH];
    logic [AW-1:0]  rd_idx;
    logic           idx_ok;
    logic           pc_bad;
    logic           rd_en;
    logic           wr_en;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        cycle_cnt_d = cycle_cnt_q;
        drain_cnt_d = drain_cnt_q;
        fault_d     = fault_q;

        // A misaligned pc is truncated to its word index rather than rejected.
        rd_idx = pc[AW+1:2];
        idx_ok = 32'(rd_idx) < DEPTH;
        pc_bad = (pc[1:0] != 2'b00) || (pc[31:AW+2] != '0) || !idx_ok;

        case (state_q)
            ST_LOAD: begin
                if (load_done) begin
                    state_d     = ST_RUN;
                    cycle_cnt_d = '0;
                    fault_d     = 1'b0;
                end
            end
            ST_RUN: begin
                cycle_cnt_d = cycle_cnt_q + 16'd1;
                if (pc_bad) begin
                    fault_d = 1'b1;
                end
                if ((cycle_cnt_q == 16'(RUN_CYCLES - 1)) || OpDone) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DCW'(DRAIN_CYCLES - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + DCW'(1);
                end
            end
            ST_DONE: begin
                if (restart) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase

        // Outputs are decoded from the next state so pcEn is high for exactly
        // the cycles spent in RUN and run_done for exactly those in DONE.
        pc_en_d    = (state_d == ST_RUN);
        run_done_d = (state_d == ST_DONE);

        // The edge leaving RUN already presents the drain NOP, not a fetch.
        rd_en = (state_q == ST_RUN) && (state_d == ST_RUN);
        wr_en = (state_q == ST_LOAD) && load_valid && reset
                && (32'(load_addr) < DEPTH);
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_LOAD;
            cycle_cnt_q <= '0;
            drain_cnt_q <= '0;
            fault_q     <= 1'b0;
            pc_en_q     <= 1'b0;
            run_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cycle_cnt_q <= cycle_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            fault_q     <= fault_d;
            pc_en_q     <= pc_en_d;
            run_done_q  <= run_done_d;
        end
    end

    // NOTE: the RAM array has no reset; the program image must survive reset
    // and restart, and a reset-free array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inst_q <= '0;
        end else if (rd_en && idx_ok) begin
            inst_q <= mem[rd_idx];
        end else begin
            inst_q <= '0;
        end
    end

    assign inst      = inst_q;
    assign pcEn      = pc_en_q;
    assign run_done  = run_done_q;
    assign fault     = fault_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: table vectors for the first fetches, then random
// pc streams checked against a word-array model and run/drain length arithmetic.
module tb_imem_fetch_ctrl;

    localparam int DEPTH        = 800;
    localparam int AW           = 10;
    localparam int RUN_CYCLES   = 804;
    localparam int DRAIN_CYCLES = 6;
    localparam int NVEC         = 7;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_valid;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          load_done;
    logic          restart;
    logic [31:0]   pc;
    logic          op_done;
    logic [31:0]   inst;
    logic          pc_en;
    logic          run_done;
    logic          fault;
    logic [15:0]   cycle_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [DEPTH];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] exp_inst;
        logic        exp_fault;
    } vec_t;

    vec_t vecs [NVEC];

    imem_fetch_ctrl #(
        .DEPTH(DEPTH), .AW(AW), .RUN_CYCLES(RUN_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
        .load_done(load_done), .restart(restart),
        .pc(pc), .OpDone(op_done),
        .inst(inst), .pcEn(pc_en), .run_done(run_done),
        .fault(fault), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned word_idx(input logic [31:0] p);
        return (p >> 2) & ((1 << AW) - 1);
    endfunction

    function automatic bit pc_bad(input logic [31:0] p);
        return (p % 4 != 0) || ((p >> (AW + 2)) != 0) || (word_idx(p) >= DEPTH);
    endfunction

    function automatic logic [31:0] model_inst(input logic [31:0] p);
        int unsigned i;
        i = word_idx(p);
        return (i < DEPTH) ? ref_mem[i] : 32'h0;
    endfunction

    function automatic logic [31:0] rand_pc();
        int unsigned r;
        r = $urandom_range(0, 99);
        if (r < 88)      return 32'($urandom_range(0, DEPTH - 1)) * 4;
        else if (r < 93) return 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
        else if (r < 97) return 32'($urandom_range(DEPTH, (1 << AW) - 1)) * 4;
        else             return 32'($urandom_range(0, DEPTH - 1)) * 4 + (32'($urandom_range(1, 15)) << 28);
    endfunction

    task automatic load_word(input int unsigned addr, input logic [31:0] data);
        load_valid = 1'b1;
        load_addr  = AW'(addr);
        load_data  = data;
        step();
        load_valid = 1'b0;
        if (addr < DEPTH) ref_mem[addr] = data;
    endtask

    // Pulses (or keeps) load_done, then follows one run to DONE. op_at is the
    // RUN cycle (cycle_cnt value) in which OpDone is raised; -1 for none.
    task automatic do_run(input int op_at, input bit use_table);
        int          exp_len;
        bit          ref_fault;
        logic [31:0] cur_pc;
        logic [31:0] exp_inst;
        exp_len = (op_at >= 0 && op_at < RUN_CYCLES) ? op_at + 1 : RUN_CYCLES;
        load_done = 1'b1;
        step();
        load_done  = 1'b0;
        load_valid = 1'b0;
        check("entry_pcen", pc_en, 1);
        check("entry_inst", inst, 0);
        check("entry_cnt", cycle_cnt, 0);
        check("entry_fault", fault, 0);
        check("entry_done", run_done, 0);
        ref_fault = 1'b0;
        for (int k = 1; k <= exp_len; k++) begin
            if (use_table && k <= NVEC) pc = vecs[k-1].pc;
            else if (k == 1)            pc = 32'h0;
            else if (k == 2)            pc = 32'd20;
            else                        pc = rand_pc();
            op_done    = (k - 1 == op_at);
            load_valid = 1'($urandom_range(0, 1));
            load_addr  = AW'($urandom_range(0, DEPTH - 1));
            load_data  = $urandom;
            cur_pc     = pc;
            step();
            if (pc_bad(cur_pc)) ref_fault = 1'b1;
            exp_inst = (k < exp_len) ? model_inst(cur_pc) : 32'h0;
            if (use_table && k <= NVEC && k < exp_len) begin
                check($sformatf("vec%0d_inst", k), inst, vecs[k-1].exp_inst);
                check($sformatf("vec%0d_fault", k), fault, vecs[k-1].exp_fault);
            end
            check($sformatf("run_inst k=%0d", k), inst, exp_inst);
            check($sformatf("run_fault k=%0d", k), fault, ref_fault);
            check($sformatf("run_pcen k=%0d", k), pc_en, (k < exp_len) ? 1 : 0);
            check($sformatf("run_cnt k=%0d", k), cycle_cnt, k);
        end
        op_done    = 1'b0;
        load_valid = 1'b0;
        for (int d = 1; d <= DRAIN_CYCLES; d++) begin
            op_done = 1'($urandom_range(0, 1));
            step();
            check($sformatf("drain_pcen d=%0d", d), pc_en, 0);
            check($sformatf("drain_inst d=%0d", d), inst, 0);
            check($sformatf("drain_done d=%0d", d), run_done, (d == DRAIN_CYCLES) ? 1 : 0);
            check($sformatf("drain_cnt d=%0d", d), cycle_cnt, exp_len);
        end
        op_done = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("done_flag", run_done, 1);
            check("done_cnt", cycle_cnt, exp_len);
            check("done_pcen", pc_en, 0);
            check("done_inst", inst, 0);
        end
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h2008_0005, 1'b0};
        vecs[1] = '{32'h0000_0004, 32'h2009_0003, 1'b0};
        vecs[2] = '{32'h0000_0008, 32'h0109_5020, 1'b0};
        vecs[3] = '{32'h0000_000C, 32'h0000_0000, 1'b0};
        vecs[4] = '{32'h0000_0C80, 32'h0000_0000, 1'b1};
        vecs[5] = '{32'h0000_0006, 32'h2009_0003, 1'b1};
        vecs[6] = '{32'h0000_0000, 32'h2008_0005, 1'b1};

        reset = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0;
        load_done = 1'b0; restart = 1'b0; pc = '0; op_done = 1'b0;
        step();
        step();
        check("rst_inst", inst, 0);
        check("rst_pcen", pc_en, 0);
        check("rst_done", run_done, 0);
        check("rst_fault", fault, 0);
        check("rst_cnt", cycle_cnt, 0);
        reset = 1'b1;

        // Program image: fixed prologue, random words everywhere else.
        load_word(0, 32'h2008_0005);
        load_word(1, 32'h2009_0003);
        load_word(2, 32'h0109_5020);
        load_word(3, 32'h0000_0000);
        for (int a = 4; a < DEPTH; a++) load_word(a, $urandom);
        load_word(900, 32'hDEAD_BEEF);
        check("oor_load_fault", fault, 0);
        check("load_pcen", pc_en, 0);

        // Full-length run with the table vectors up front.
        do_run(-1, 1'b1);

        // restart held for two cycles stays in LOAD.
        restart = 1'b1;
        step();
        check("restart_done", run_done, 0);
        check("restart_pcen", pc_en, 0);
        step();
        restart = 1'b0;
        check("restart_hold_done", run_done, 0);
        check("restart_hold_pcen", pc_en, 0);

        // A write coinciding with load_done still lands (read back at k=2).
        load_word(7, $urandom);
        load_valid = 1'b1;
        load_addr  = AW'(5);
        load_data  = $urandom;
        ref_mem[5] = load_data;
        do_run(100, 1'b0);

        // load_done already high when LOAD is entered.
        restart   = 1'b1;
        load_done = 1'b1;
        step();
        restart = 1'b0;
        check("reentry_done", run_done, 0);
        check("reentry_pcen", pc_en, 0);
        check("reentry_cnt", cycle_cnt, 101);
        do_run(RUN_CYCLES - 1, 1'b0);

        // Asynchronous reset in the middle of RUN.
        restart = 1'b1;
        step();
        restart   = 1'b0;
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        for (int k = 0; k < 50; k++) begin
            pc = (k == 10) ? 32'h6 : 32'($urandom_range(0, DEPTH - 1)) * 4;
            step();
        end
        check("pre_rst_pcen", pc_en, 1);
        check("pre_rst_fault", fault, 1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_inst", inst, 0);
        check("async_rst_pcen", pc_en, 0);
        check("async_rst_done", run_done, 0);
        check("async_rst_fault", fault, 0);
        check("async_rst_cnt", cycle_cnt, 0);
        step();
        check("held_rst_pcen", pc_en, 0);
        check("held_rst_cnt", cycle_cnt, 0);
        #2 reset = 1'b1;

        // Rerun without reloading: RAM contents survive reset.
        do_run(int'($urandom_range(0, 300)), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
